// File: rtl/prio_enc_pkg.sv
// Shared types, constants and priority helper for the
// 8-to-3 priority encoder.
package prio_enc_pkg;

    localparam int N_REQ  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    // Later loop hits overwrite earlier ones, so the scan order
    // decides which set bit wins.
    function automatic logic [CODE_W-1:0] prio_index(
        input logic [N_REQ-1:0] vec,
        input logic             high_first
    );
        logic [CODE_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (high_first) begin
                if (vec[i])
                    idx = CODE_W'(i);
            end else begin
                if (vec[N_REQ-1-i])
                    idx = CODE_W'(N_REQ-1-i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/req_sync_edge.sv
// Per-bit synchronizer chain plus falling-edge detector
// for the active-low request lines.
module req_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter int W           = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] req_n,
    output logic [W-1:0] fall
);

    logic [W-1:0] sync_q [SYNC_STAGES];
    logic [W-1:0] delay_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '1;
            delay_q <= '1;
        end else begin
            sync_q[0] <= req_n;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            delay_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign fall = delay_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/prio_encoder_8to3.sv
// Clocked 8-to-3 priority encoder: captures request edges into
// a pending set and hands them out one code at a time.
import prio_enc_pkg::*;

module prio_encoder_8to3 #(
    parameter int SYNC_STAGES = 2,
    parameter bit HIGH_FIRST  = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  req_n,
    input  logic              ei_n,
    input  logic              ack,
    output logic [CODE_W-1:0] code,
    output logic              valid,
    output logic              gs_n,
    output logic [N_REQ-1:0]  pending,
    output logic              overrun
);

    logic [N_REQ-1:0]  fall;
    logic [N_REQ-1:0]  pending_q;
    logic [N_REQ-1:0]  pending_d;
    logic [N_REQ-1:0]  clr_mask;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_d;
    logic              ov_q;
    logic              ov_d;
    logic              gs_n_q;
    state_t            state_q;
    state_t            state_d;

    req_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES),
        .W          (N_REQ)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .req_n(req_n),
        .fall (fall)
    );

    // A fresh edge on the bit being acked wins over the clear.
    always_comb begin
        clr_mask = '0;
        if (state_q == PRESENT && ack)
            clr_mask[code_q] = 1'b1;
        pending_d = (pending_q & ~clr_mask) | fall;
        ov_d      = |(fall & pending_q & ~clr_mask);
    end

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (!ei_n && |pending_q) begin
                    code_d  = prio_index(pending_q, HIGH_FIRST);
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (ack)
                    state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            code_q    <= '0;
            pending_q <= '0;
            ov_q      <= 1'b0;
            gs_n_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            pending_q <= pending_d;
            ov_q      <= ov_d;
            gs_n_q    <= ~|pending_q;
        end
    end

    assign code    = code_q;
    assign valid   = (state_q == PRESENT);
    assign gs_n    = gs_n_q;
    assign pending = pending_q;
    assign overrun = ov_q;

endmodule

// File: tb/tb_prio_encoder_8to3.sv
// Scoreboard bench: two encoder instances (both priority orders)
// share stimulus; monitors check each presented code.
module tb_prio_encoder_8to3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] req_n = 8'hFF;
    logic       ei_n = 1'b0;
    logic       ack = 1'b0;

    logic [2:0] code_hi, code_lo;
    logic       valid_hi, valid_lo;
    logic       gs_n_hi, gs_n_lo;
    logic [7:0] pend_hi, pend_lo;
    logic       ov_hi, ov_lo;

    int n_pass = 0;
    int n_total = 0;
    int q_hi[$];
    int q_lo[$];
    int ov_hi_cnt = 0;
    int ov_lo_cnt = 0;
    logic pv_hi = 1'b0;
    logic pv_lo = 1'b0;

    always #5 clk = ~clk;

    prio_encoder_8to3 #(.SYNC_STAGES(2), .HIGH_FIRST(1'b1)) dut_hi (
        .clk(clk), .rst_n(rst_n), .req_n(req_n), .ei_n(ei_n),
        .ack(ack), .code(code_hi), .valid(valid_hi),
        .gs_n(gs_n_hi), .pending(pend_hi), .overrun(ov_hi)
    );

    prio_encoder_8to3 #(.SYNC_STAGES(2), .HIGH_FIRST(1'b0)) dut_lo (
        .clk(clk), .rst_n(rst_n), .req_n(req_n), .ei_n(ei_n),
        .ack(ack), .code(code_lo), .valid(valid_lo),
        .gs_n(gs_n_lo), .pending(pend_lo), .overrun(ov_lo)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: a set of captured events is served in
    // priority order, highest index first or lowest index first.
    task automatic expect_events(input logic [7:0] mask);
        for (int i = 7; i >= 0; i--)
            if (mask[i]) q_hi.push_back(i);
        for (int i = 0; i < 8; i++)
            if (mask[i]) q_lo.push_back(i);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_hi = 1'b0;
        end else begin
            if (valid_hi && !pv_hi) begin
                if (q_hi.size() == 0) begin
                    n_total++;
                    $display("FAIL hi_unexpected: got code %0d expected none",
                             code_hi);
                end else begin
                    chk("hi_code", 32'(code_hi), q_hi.pop_front());
                end
            end
            pv_hi = valid_hi;
            if (ov_hi) ov_hi_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pv_lo = 1'b0;
        end else begin
            if (valid_lo && !pv_lo) begin
                if (q_lo.size() == 0) begin
                    n_total++;
                    $display("FAIL lo_unexpected: got code %0d expected none",
                             code_lo);
                end else begin
                    chk("lo_code", 32'(code_lo), q_lo.pop_front());
                end
            end
            pv_lo = valid_lo;
            if (ov_lo) ov_lo_cnt++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!(valid_hi && valid_lo) && n < 40) begin
            step(1);
            n++;
        end
        chk(name, 32'(valid_hi & valid_lo), 32'd1);
    endtask

    task automatic ack_once();
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("ack_drop", {valid_hi, valid_lo}, 32'd0);
    endtask

    initial begin
        logic [7:0] mask;
        int         nbits;

        // Reset with all lines low
        req_n = 8'h00;
        step(3);
        chk("rst_valid", {valid_hi, valid_lo}, 32'd0);
        chk("rst_code", {code_hi, code_lo}, 32'd0);
        chk("rst_pend", {pend_hi, pend_lo}, 32'd0);
        chk("rst_gs", {gs_n_hi, gs_n_lo}, 32'd3);
        chk("rst_ov", {ov_hi, ov_lo}, 32'd0);
        req_n = 8'hFF;
        step(1);
        rst_n = 1'b1;
        step(6);
        chk("rel_pend", {pend_hi, pend_lo}, 32'd0);
        chk("rel_valid", {valid_hi, valid_lo}, 32'd0);

        // Single request latency
        expect_events(8'h20);
        req_n[5] = 1'b0;
        step(3);
        chk("single_pend", {pend_hi, pend_lo}, 32'h2020);
        chk("single_novalid", {valid_hi, valid_lo}, 32'd0);
        step(1);
        chk("single_valid", {valid_hi, valid_lo}, 32'd3);
        chk("single_code", {code_hi, code_lo}, {3'd5, 3'd5});
        chk("single_gs", {gs_n_hi, gs_n_lo}, 32'd0);
        ack_once();
        chk("single_clr", {pend_hi, pend_lo}, 32'd0);
        step(1);
        chk("single_gs_off", {gs_n_hi, gs_n_lo}, 32'd3);
        req_n = 8'hFF;
        step(4);

        // Priority ordering of simultaneous events
        expect_events(8'h52);
        req_n = ~8'h52;
        for (int k = 0; k < 3; k++) begin
            wait_valid("prio_wait");
            ack_once();
        end
        req_n = 8'hFF;
        step(4);

        // No preemption
        expect_events(8'h04);
        req_n[2] = 1'b0;
        wait_valid("nopre_wait");
        req_n[7] = 1'b0;
        step(5);
        chk("nopre_code", {code_hi, code_lo}, {3'd2, 3'd2});
        chk("nopre_pend", {pend_hi, pend_lo}, 32'h8484);
        expect_events(8'h80);
        ack_once();
        wait_valid("nopre_wait7");
        ack_once();
        req_n = 8'hFF;
        step(4);

        // Enable gating
        ei_n = 1'b1;
        req_n[3] = 1'b0;
        step(5);
        chk("ei_pend", {pend_hi, pend_lo}, 32'h0808);
        chk("ei_novalid", {valid_hi, valid_lo}, 32'd0);
        expect_events(8'h08);
        ei_n = 1'b0;
        wait_valid("ei_wait");
        ack_once();
        req_n = 8'hFF;
        step(4);

        // Overrun on a bit already pending
        expect_events(8'h01);
        req_n[0] = 1'b0;
        wait_valid("ov_wait");
        ov_hi_cnt = 0;
        ov_lo_cnt = 0;
        req_n[0] = 1'b1;
        step(3);
        req_n[0] = 1'b0;
        step(6);
        chk("ov_hi_cnt", ov_hi_cnt, 32'd1);
        chk("ov_lo_cnt", ov_lo_cnt, 32'd1);
        chk("ov_pend", {pend_hi, pend_lo}, 32'h0101);
        ack_once();
        step(3);
        chk("ov_merged", {pend_hi, pend_lo}, 32'd0);
        req_n = 8'hFF;
        step(4);

        // Edge on the presented bit during the ack cycle
        expect_events(8'h02);
        req_n[1] = 1'b0;
        wait_valid("sw_wait");
        req_n[1] = 1'b1;
        step(4);
        ov_hi_cnt = 0;
        ov_lo_cnt = 0;
        req_n[1] = 1'b0;
        step(2);
        expect_events(8'h02);
        ack = 1'b1;
        step(1);
        ack = 1'b0;
        chk("sw_novalid", {valid_hi, valid_lo}, 32'd0);
        chk("sw_pend", {pend_hi, pend_lo}, 32'h0202);
        wait_valid("sw_again");
        ack_once();
        chk("sw_no_ov", ov_hi_cnt + ov_lo_cnt, 32'd0);
        req_n = 8'hFF;
        step(4);

        // Randomized event sets
        for (int it = 0; it < 10; it++) begin
            mask = 8'($urandom_range(1, 255));
            nbits = $countones(mask);
            expect_events(mask);
            req_n = ~mask;
            for (int k = 0; k < nbits; k++) begin
                wait_valid("rnd_wait");
                step($urandom_range(0, 3));
                ack_once();
            end
            req_n = 8'hFF;
            step(4);
            chk("rnd_empty", {pend_hi, pend_lo}, 32'd0);
        end

        // Asynchronous reset while presenting
        expect_events(8'h40);
        req_n[6] = 1'b0;
        wait_valid("ar_wait");
        req_n[4] = 1'b0;
        step(4);
        chk("ar_pend_pre", {pend_hi, pend_lo}, 32'h5050);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {valid_hi, valid_lo}, 32'd0);
        chk("ar_pend", {pend_hi, pend_lo}, 32'd0);
        chk("ar_gs", {gs_n_hi, gs_n_lo}, 32'd3);
        req_n = 8'hFF;
        step(2);
        rst_n = 1'b1;
        step(10);
        chk("ar_stale_valid", {valid_hi, valid_lo}, 32'd0);
        chk("ar_stale_pend", {pend_hi, pend_lo}, 32'd0);

        chk("q_hi_drained", q_hi.size(), 32'd0);
        chk("q_lo_drained", q_lo.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
